note_sequencer: RTL and testbench

- Buffers note commands written by the microcontroller through an output port and plays them one at a time.
- Each command is held for a timed duration. The block drives audio_enable, a note code, and short/long strobes into the sound module, which feeds the audio DAC.
- An inter-note gap separates consecutive notes.
- Sits between the microcontroller output-port registers and the sound generator, on the system clock.

---
 rtl/note_sequencer.sv | 143 ++++++++++++++
 tb/tb_note_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: buffers microcontroller note commands in a FIFO and plays each one for a timed duration,
// with a silent gap after every note or rest.
module note_sequencer #(
    parameter int TICK_DIV    = 50000,
    parameter int SHORT_TICKS = 150,
    parameter int LONG_TICKS  = 450,
    parameter int GAP_TICKS   = 50,
    parameter int DEPTH       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic [3:0] count,
    output logic       overflow,
    output logic       busy,
    output logic       audio_enable,
    output logic [3:0] note,
    output logic       short,
    output logic       long
);
    localparam int AW     = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int MAX_PS = LONG_TICKS > SHORT_TICKS ? LONG_TICKS : SHORT_TICKS;
    localparam int MAX_T  = MAX_PS > GAP_TICKS ? MAX_PS : GAP_TICKS;
    localparam int TW     = MAX_T > 1 ? $clog2(MAX_T) : 1;
    localparam int PW     = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    logic [5:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [3:0]    r_count;
    logic          r_full, r_empty, r_overflow;
    state_t        r_state;
    logic          r_pending;
    logic [3:0]    r_code;
    logic [1:0]    r_kind;
    logic [PW-1:0] r_pre;
    logic [TW-1:0] r_ticks;
    logic          r_audio, r_short, r_long;
    logic [3:0]    r_note;

    logic [5:0] w_head;
    logic       w_pop, w_flush, w_push, w_drop, w_tick, w_play_last, w_gap_last;
    logic [3:0] w_count_nxt;
    logic       w_unused;

    assign w_unused    = ^wr_data[1:0];
    assign w_head      = r_mem[r_rd_ptr];
    // The pop cycle only latches the command; PLAY starts on the following edge.
    assign w_pop       = r_state == IDLE && !r_pending && !r_empty;
    assign w_flush     = w_pop && w_head[1:0] == 2'b11;
    assign w_push      = wr_en && !w_flush && (r_count != 4'(DEPTH) || w_pop);
    assign w_drop      = wr_en && r_count == 4'(DEPTH) && !w_pop;
    assign w_count_nxt = w_flush ? 4'd0 : r_count + {3'b0, w_push} - {3'b0, w_pop};
    assign w_tick      = r_pre == PW'(TICK_DIV - 1);
    assign w_play_last = r_ticks == (r_kind == 2'b01 ? TW'(LONG_TICKS - 1) : TW'(SHORT_TICKS - 1));
    assign w_gap_last  = r_ticks == TW'(GAP_TICKS - 1);

    assign full         = r_full;
    assign empty        = r_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign busy         = r_state != IDLE;
    assign audio_enable = r_audio;
    assign note         = r_note;
    assign short        = r_short;
    assign long         = r_long;

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr_ptr] <= wr_data[7:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_flush) r_rd_ptr <= r_wr_ptr;
            else if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= w_count_nxt;
            r_full     <= w_count_nxt == 4'(DEPTH);
            r_empty    <= w_count_nxt == 4'd0;
            r_overflow <= r_overflow | w_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_code    <= '0;
            r_kind    <= '0;
            r_pre     <= '0;
            r_ticks   <= '0;
            r_audio   <= 1'b0;
            r_note    <= '0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_pending) begin
                        r_state   <= PLAY;
                        r_pending <= 1'b0;
                        r_pre     <= '0;
                        r_ticks   <= '0;
                        r_audio   <= r_kind != 2'b10;
                        r_note    <= r_kind == 2'b10 ? 4'd0 : r_code;
                        r_short   <= r_kind == 2'b00;
                        r_long    <= r_kind == 2'b01;
                    end else if (w_pop && !w_flush) begin
                        r_pending <= 1'b1;
                        r_code    <= w_head[5:2];
                        r_kind    <= w_head[1:0];
                    end
                end
                PLAY: begin
                    r_pre <= w_tick ? '0 : r_pre + PW'(1);
                    if (w_tick && w_play_last) begin
                        r_state <= GAP;
                        r_ticks <= '0;
                        r_audio <= 1'b0;
                        r_short <= 1'b0;
                        r_long  <= 1'b0;
                    end else if (w_tick) r_ticks <= r_ticks + TW'(1);
                end
                GAP: begin
                    r_pre <= w_tick ? '0 : r_pre + PW'(1);
                    if (w_tick && w_gap_last) r_state <= IDLE;
                    else if (w_tick) r_ticks <= r_ticks + TW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: table vectors plus hand sequences; a scoreboard queue holds the expected
// note/strobes and busy/audio lengths of every command that should play.
module tb_note_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, busy, audio_enable, short, long;
    logic [3:0] count, note;

    note_sequencer #(.TICK_DIV(4), .SHORT_TICKS(3), .LONG_TICKS(6), .GAP_TICKS(1), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .busy(busy), .audio_enable(audio_enable), .note(note),
        .short(short), .long(long)
    );

    always #5 clk = ~clk;

    typedef struct {int nt; int sh; int lg; int au; int blen; int alen;} exp_t;
    typedef struct {logic [7:0] cmd; exp_t e;} vec_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input int nt, input int sh, input int lg, input int au, input int blen, input int alen);
        exp_t e;
        e.nt = nt; e.sh = sh; e.lg = lg; e.au = au; e.blen = blen; e.alen = alen;
        return e;
    endfunction

    bit   prev_busy = 1'b0;
    bit   in_note = 1'b0;
    int   blen, alen;
    exp_t cur;

    always @(negedge clk) begin
        if (reset) in_note = 1'b0;
        else if (busy && !prev_busy) begin
            chk("sb_has_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                chk("start_note", note, cur.nt);
                chk("start_short", short, cur.sh);
                chk("start_long", long, cur.lg);
                chk("start_audio", audio_enable, cur.au);
                in_note = 1'b1;
                blen = 1;
                alen = audio_enable;
            end
        end else if (busy && in_note) begin
            blen++;
            alen += audio_enable;
            if (note !== 4'(cur.nt)) chk("note_stable", note, cur.nt);
        end else if (!busy && prev_busy && in_note) begin
            chk("busy_len", blen, cur.blen);
            chk("audio_len", alen, cur.alen);
            in_note = 1'b0;
        end
        prev_busy = reset ? 1'b0 : busy;
    end

    task automatic put(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(sb.size() == 0 && !busy && empty && !in_note) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_within_budget", int'(n < budget), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_audio"}, audio_enable, 0);
        chk({tag, "_note"}, note, 0);
        chk({tag, "_short"}, short, 0);
        chk({tag, "_long"}, long, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   n;
        vecs[0] = '{8'h50, mk(5, 1, 0, 1, 16, 12)};
        vecs[1] = '{8'h34, mk(3, 0, 1, 1, 28, 24)};
        vecs[2] = '{8'h08, mk(0, 0, 0, 0, 16, 0)};
        vecs[3] = '{8'hF4, mk(15, 0, 1, 1, 28, 24)};
        vecs[4] = '{8'h02, mk(0, 1, 0, 1, 16, 12)};
        vecs[5] = '{8'hAB, mk(0, 0, 0, 0, 16, 0)};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst");
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("idle20");
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            sb.push_back(vecs[i].e);
            put(vecs[i].cmd);
            @(negedge clk);
            chk("lat_count_after_write", count, 1);
            chk("lat_busy_after_write", busy, 0);
            @(negedge clk);
            chk("lat_count_after_pop", count, 0);
            chk("lat_audio_after_pop", audio_enable, 0);
            @(negedge clk);
            chk("lat_audio_in_play", audio_enable, vecs[i].e.au);
            chk("lat_busy_in_play", busy, 1);
            @(posedge clk); #1;
            wait_idle(100);
        end

        sb.push_back(mk(3, 0, 1, 1, 28, 24));
        sb.push_back(mk(0, 0, 0, 0, 16, 0));
        put(8'h34);
        put(8'h08);
        n = 0;
        while (!busy && n < 50) begin @(posedge clk); #1; n++; end
        n = 0;
        while (busy && n < 100) begin @(posedge clk); #1; n++; end
        n = 0;
        while (!busy && n < 50) begin @(posedge clk); #1; n++; end
        chk("b2b_idle_cycles", n, 2);
        wait_idle(100);

        for (int i = 0; i < 9; i++) begin
            sb.push_back(mk(i + 1, 1, 0, 1, 16, 12));
            put({4'(i + 1), 4'b0000});
        end
        @(negedge clk);
        chk("fill_count", count, 8);
        chk("fill_full", full, 1);
        chk("fill_overflow", overflow, 0);
        @(posedge clk); #1;
        put(8'hE4);
        @(negedge clk);
        chk("drop_overflow", overflow, 1);
        chk("drop_count", count, 8);
        chk("drop_full", full, 1);
        @(posedge clk); #1;
        wait_idle(400);
        chk("drop_overflow_sticky", overflow, 1);
        chk("drained_empty", empty, 1);

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ovf_cleared_by_reset", overflow, 0);
        @(posedge clk); #1;

        sb.push_back(mk(5, 1, 0, 1, 16, 12));
        sb.push_back(mk(6, 1, 0, 1, 16, 12));
        put(8'h50);
        put(8'h60);
        put(8'h0C);
        put(8'h70);
        wait_idle(200);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("flush_empty", empty, 1);
        chk("flush_count", count, 0);
        chk("flush_busy", busy, 0);
        @(posedge clk); #1;

        sb.push_back(mk(3, 0, 1, 1, 28, 24));
        put(8'h34);
        put(8'h50);
        put(8'h60);
        put(8'h70);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_abort_long", long, 1);
        chk("pre_abort_count", count, 3);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_audio", audio_enable, 0);
        chk("abort_count", count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_long", long, 0);
        chk("abort_empty", empty, 1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("abort_stays_idle", busy, 0);
        @(posedge clk); #1;
        sb.push_back(mk(9, 1, 0, 1, 16, 12));
        put(8'h90);
        wait_idle(100);
        chk("sb_leftover", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
